// File: rtl/vram_arbiter_if.sv
// VRAM arbiter port bundle: CPU write, scanout read,
// clear-engine control and single-port RAM side.
interface vram_arbiter_if #(
  parameter int AW = 7
);
  logic          cpu_req_valid;
  logic [AW-1:0] cpu_req_addr;
  logic [31:0]   cpu_req_data;
  logic          cpu_req_ready;
  logic          scan_req_valid;
  logic [AW-1:0] scan_req_addr;
  logic          scan_rsp_valid;
  logic [31:0]   scan_rsp_data;
  logic          clr_start;
  logic [31:0]   clr_pattern;
  logic          clr_busy;
  logic          clr_done;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_data,
    output cpu_req_ready,
    input  scan_req_valid, scan_req_addr,
    output scan_rsp_valid, scan_rsp_data,
    input  clr_start, clr_pattern,
    output clr_busy, clr_done,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_data,
    input  cpu_req_ready,
    output scan_req_valid, scan_req_addr,
    input  scan_rsp_valid, scan_rsp_data,
    output clr_start, clr_pattern,
    input  clr_busy, clr_done,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout > starved clear > CPU > clear,
// with a fill engine that writes a latched pattern to every word.
module vram_arbiter #(
  parameter int DEPTH        = 128,
  parameter int AW           = 7,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst,
  vram_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] clr_addr, clr_addr_nx;
  logic [SW-1:0] starve_cnt, starve_nx;
  logic [31:0]   pattern, pattern_nx;
  logic          rsp_valid;
  logic          in_clr, starved;
  logic          g_scan, g_cpu, g_clr;

  assign in_clr  = (state == CLEAR);
  assign starved = in_clr && (starve_cnt == SW'(STARVE_LIMIT));

  // grants are gated by rst so the RAM side is quiet during reset
  assign g_scan = rst && bus.scan_req_valid;
  assign g_cpu  = rst && !bus.scan_req_valid && !starved
                  && bus.cpu_req_valid;
  assign g_clr  = rst && !bus.scan_req_valid && in_clr
                  && (starved || !bus.cpu_req_valid);

  always_comb begin
    bus.ram_en        = 1'b0;
    bus.ram_we        = 1'b0;
    bus.ram_addr      = '0;
    bus.ram_wdata     = '0;
    bus.cpu_req_ready = 1'b0;
    unique case (1'b1)
      g_scan: begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = bus.scan_req_addr;
      end
      g_cpu: begin
        bus.ram_en        = 1'b1;
        bus.ram_we        = 1'b1;
        bus.ram_addr      = bus.cpu_req_addr;
        bus.ram_wdata     = bus.cpu_req_data;
        bus.cpu_req_ready = 1'b1;
      end
      g_clr: begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = clr_addr;
        bus.ram_wdata = pattern;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    pattern_nx  = pattern;
    starve_nx   = starve_cnt;
    unique case (state)
      IDLE: begin
        if (bus.clr_start) begin
          state_nx    = CLEAR;
          clr_addr_nx = '0;
          pattern_nx  = bus.clr_pattern;
        end
      end
      CLEAR: begin
        if (g_clr) begin
          clr_addr_nx = clr_addr + AW'(1);
          if (clr_addr == AW'(DEPTH - 1))
            state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!in_clr || g_clr)
      starve_nx = '0;
    else if (g_cpu && !starved)
      starve_nx = starve_cnt + SW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      clr_addr   <= '0;
      starve_cnt <= '0;
      pattern    <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      state      <= state_nx;
      clr_addr   <= clr_addr_nx;
      starve_cnt <= starve_nx;
      pattern    <= pattern_nx;
      rsp_valid  <= g_scan;
    end
  end

  // RAM read data arrives the cycle after the scan grant
  assign bus.scan_rsp_valid = rsp_valid;
  assign bus.scan_rsp_data  = rsp_valid ? bus.ram_rdata : '0;
  assign bus.clr_busy       = in_clr;
  assign bus.clr_done       = (state == DONE);
endmodule
